pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It consumes the stall and redirect requests raised by hazard detection, branch resolution and data-memory wait, and drives the per-stage register enables, bubble and flush controls, and per-stage valid bits. It also runs a halt/drain/resume state machine. It sits between the combinational hazard logic and the F/D, D/E, E/M, M/W pipeline registers and the PC register.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_sat_counter.sv | 31 +++
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the controller state encoding and the pipeline stage indices.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, flushes, valid tracking and halt/drain FSM.
// Optional stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             HAZ_STALL,
  input  logic             BR_TAKEN,
  input  logic             MEM_BUSY,
  input  logic             IMEM_VALID,
  input  logic             HALT_REQ,
  input  logic             RESUME,
  output logic             PC_EN,
  output logic             PC_SEL,
  output logic             FD_EN,
  output logic             DE_EN,
  output logic             EM_EN,
  output logic             MW_EN,
  output logic             FD_FLUSH,
  output logic             DE_FLUSH,
  output logic             D_VALID,
  output logic             E_VALID,
  output logic             M_VALID,
  output logic             W_VALID,
  output logic             HALT_ACK
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

  pipe_state_t          state_q;
  pipe_state_t          state_d;
  logic [STG_W:STG_D]   vld_q;
  logic [STG_W:STG_D]   vld_d;
  logic                 halt_ack_q;
  logic                 halt_ack_d;

  logic                 br_eff;
  logic                 stall_eff;
  logic                 fetch_ok;
  logic [STG_W:STG_F]   chain;

  // A redirect only counts when E actually holds a live branch; it masks any stall.
  assign br_eff    = BR_TAKEN && vld_q[STG_E];
  assign stall_eff = HAZ_STALL && !br_eff;
  assign fetch_ok  = IMEM_VALID && (state_q == RUN);
  assign chain     = {vld_q, fetch_ok};

  always_comb begin
    PC_EN      = 1'b0;
    PC_SEL     = 1'b0;
    FD_EN      = 1'b0;
    DE_EN      = 1'b0;
    EM_EN      = 1'b0;
    MW_EN      = 1'b0;
    FD_FLUSH   = 1'b0;
    DE_FLUSH   = 1'b0;
    vld_d      = vld_q;
    state_d    = state_q;
    halt_ack_d = halt_ack_q;

    if (RST) begin
      FD_FLUSH = 1'b1;
      DE_FLUSH = 1'b1;
    end else if (!MEM_BUSY) begin
      if (br_eff) begin
        PC_EN    = 1'b1;
        PC_SEL   = 1'b1;
        FD_EN    = 1'b1;
        DE_EN    = 1'b1;
        EM_EN    = 1'b1;
        MW_EN    = 1'b1;
        FD_FLUSH = 1'b1;
        DE_FLUSH = 1'b1;
        vld_d[STG_W:STG_M] = vld_q[STG_M:STG_E];
        vld_d[STG_E]       = 1'b0;
        vld_d[STG_D]       = 1'b0;
      end else if (stall_eff) begin
        DE_EN    = 1'b1;
        EM_EN    = 1'b1;
        MW_EN    = 1'b1;
        DE_FLUSH = 1'b1;
        vld_d[STG_W:STG_M] = vld_q[STG_M:STG_E];
        vld_d[STG_E]       = 1'b0;
      end else begin
        PC_EN = (state_q == RUN);
        FD_EN = 1'b1;
        DE_EN = 1'b1;
        EM_EN = 1'b1;
        MW_EN = 1'b1;
        vld_d = chain[STG_M:STG_F];
      end

      // Drain completes once the valid bits being written this cycle are all clear.
      case (state_q)
        RUN:     if (HALT_REQ) state_d = DRAIN;
        DRAIN:   if (vld_d == '0) state_d = HALTED;
        HALTED:  if (RESUME) state_d = RUN;
        default: state_d = RUN;
      endcase

      halt_ack_d = (state_q == HALTED) && !RESUME;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      vld_q      <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      halt_ack_q <= halt_ack_d;
    end
  end

  assign D_VALID  = vld_q[STG_D];
  assign E_VALID  = vld_q[STG_E];
  assign M_VALID  = vld_q[STG_M];
  assign W_VALID  = vld_q[STG_W];
  assign HALT_ACK = halt_ack_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !MEM_BUSY && stall_eff;
  assign flush_inc = !MEM_BUSY && br_eff;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (stall_inc),
    .count (STALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (flush_inc),
    .count (FLUSH_CNT)
  );
`else
  logic unused_perf_width;
  assign unused_perf_width = |CNT_W;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (fill, stall, redirect, freeze, drain/halt/resume, reset).
// Counter checks are compiled in when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  localparam logic [7:0] EN_RESET  = 8'h03;
  localparam logic [7:0] EN_RUN    = 8'hBC;
  localparam logic [7:0] EN_DRAIN  = 8'h3C;
  localparam logic [7:0] EN_STALL  = 8'h1D;
  localparam logic [7:0] EN_BR     = 8'hFF;
  localparam logic [7:0] EN_FROZEN = 8'h00;

  logic clk = 1'b0;
  logic rst;
  logic haz_stall, br_taken, mem_busy, imem_valid, halt_req, resume;
  logic pc_en, pc_sel, fd_en, de_en, em_en, mw_en, fd_flush, de_flush;
  logic d_valid, e_valid, m_valid, w_valid, halt_ack;
`ifdef PIPE_CTRL_PERF_EN
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
`endif

  logic [7:0] en_vec;
  logic [3:0] vld_vec;

  int tests_run    = 0;
  int tests_failed = 0;

  assign en_vec  = {pc_en, pc_sel, fd_en, de_en, em_en, mw_en, fd_flush, de_flush};
  assign vld_vec = {d_valid, e_valid, m_valid, w_valid};

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(4)) dut (
    .CLK        (clk),
    .RST        (rst),
    .HAZ_STALL  (haz_stall),
    .BR_TAKEN   (br_taken),
    .MEM_BUSY   (mem_busy),
    .IMEM_VALID (imem_valid),
    .HALT_REQ   (halt_req),
    .RESUME     (resume),
    .PC_EN      (pc_en),
    .PC_SEL     (pc_sel),
    .FD_EN      (fd_en),
    .DE_EN      (de_en),
    .EM_EN      (em_en),
    .MW_EN      (mw_en),
    .FD_FLUSH   (fd_flush),
    .DE_FLUSH   (de_flush),
    .D_VALID    (d_valid),
    .E_VALID    (e_valid),
    .M_VALID    (m_valid),
    .W_VALID    (w_valid),
    .HALT_ACK   (halt_ack)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .STALL_CNT  (stall_cnt),
    .FLUSH_CNT  (flush_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic haz, input logic br, input logic mem,
                               input logic imem, input logic halt, input logic res);
    haz_stall  = haz;
    br_taken   = br;
    mem_busy   = mem;
    imem_valid = imem;
    halt_req   = halt;
    resume     = res;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] fill_exp [4];
    logic [3:0] drain_exp [4];
    fill_exp  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    drain_exp = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_enables", en_vec, EN_RESET);
    tick();
    tick();
    checkOutput("reset_valids", vld_vec, 4'b0000);
    checkOutput("reset_halt_ack", halt_ack, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("reset_stall_cnt", stall_cnt, 4'd0);
    checkOutput("reset_flush_cnt", flush_cnt, 4'd0);
`endif

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("run_enables", en_vec, EN_RUN);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("fill_valids_%0d", i + 1), vld_vec, fill_exp[i]);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_enables", en_vec, EN_STALL);
    tick();
    checkOutput("stall_valids", vld_vec, 4'b1011);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("stall_cnt_one", stall_cnt, 4'd1);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("post_stall_valids", vld_vec, 4'b1101);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_over_stall_enables", en_vec, EN_BR);
    tick();
    checkOutput("br_valids", vld_vec, 4'b0010);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("br_stall_cnt_held", stall_cnt, 4'd1);
    checkOutput("br_flush_cnt_one", flush_cnt, 4'd1);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("refill_valids_a", vld_vec, 4'b1001);
    tick();
    checkOutput("refill_valids_b", vld_vec, 4'b1100);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("frozen_enables", en_vec, EN_FROZEN);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("frozen_valids_%0d", i), vld_vec, 4'b1100);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("unfrozen_br_enables", en_vec, EN_BR);
    tick();
    checkOutput("unfrozen_br_valids", vld_vec, 4'b0010);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("flush_cnt_two", flush_cnt, 4'd2);
`endif

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("unqualified_br_enables", en_vec, EN_RUN);
    tick();
    checkOutput("unqualified_br_valids", vld_vec, 4'b1001);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("unqualified_flush_cnt", flush_cnt, 4'd2);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("full_again_valids", vld_vec, 4'b1111);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("halt_req_enables", en_vec, EN_RUN);
    tick();
    checkOutput("halt_req_valids", vld_vec, 4'b1111);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_enables", en_vec, EN_DRAIN);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("drain_valids_%0d", i), vld_vec, drain_exp[i]);
    end
    checkOutput("halt_ack_not_yet", halt_ack, 1'b0);
    tick();
    checkOutput("halt_ack_set", halt_ack, 1'b1);
    checkOutput("halted_enables", en_vec, EN_DRAIN);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("halted_ignores_halt_req", halt_ack, 1'b1);
    checkOutput("halted_no_fetch", vld_vec, 4'b0000);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("resume_halt_ack_clear", halt_ack, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("resume_enables", en_vec, EN_RUN);
    tick();
    checkOutput("resume_first_fetch", vld_vec, 4'b1000);

    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_mid_stall_enables", en_vec, EN_RESET);
    tick();
    checkOutput("reset_mid_stall_valids", vld_vec, 4'b0000);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("reset_mid_stall_cnt", stall_cnt, 4'd0);
    checkOutput("reset_mid_flush_cnt", flush_cnt, 4'd0);
`endif
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_no_pending", en_vec, EN_RUN);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (14) tick();
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("stall_cnt_14", stall_cnt, 4'd14);
`endif
    tick();
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("stall_cnt_15", stall_cnt, 4'd15);
`endif
    tick();
    tick();
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("stall_cnt_saturated", stall_cnt, 4'd15);
`endif
    checkOutput("stall_stream_valids", vld_vec, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
